key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 167 ++++++++++++++++
 tb/tb_key_conditioner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects active-low push-buttons.
// Each key has its own 4-state debounce FSM and saturating qualification counter.
// Optional feature: define KEY_RELEASE_PULSE_EN to add the release_pulse port and logic.
`timescale 1ns/1ps

module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] press_pulse
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [NUM_KEYS-1:0] release_pulse
`endif
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] sample;
    logic [NUM_KEYS-1:0] down_nxt;
    logic [NUM_KEYS-1:0] press_nxt;
`ifdef KEY_RELEASE_PULSE_EN
    logic [NUM_KEYS-1:0] release_nxt;
`endif

    // Two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign sample = ~sync2;

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] cnt_inc;
        logic             down_c;
        logic             press_c;
`ifdef KEY_RELEASE_PULSE_EN
        logic             release_c;
`endif

        // Saturating increment of the qualification counter
        assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

        // State and counter register
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state <= RELEASED;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next-state and counter logic
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                RELEASED: begin
                    if (sample[g]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sample[g]) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!sample[g]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sample[g]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Output decode from the transition being taken this cycle
        always_comb begin
            down_c  = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            press_c = (state == PRESS_WAIT) && (state_nxt == PRESSED);
`ifdef KEY_RELEASE_PULSE_EN
            release_c = (state == RELEASE_WAIT) && (state_nxt == RELEASED);
`endif
        end

        assign down_nxt[g]  = down_c;
        assign press_nxt[g] = press_c;
`ifdef KEY_RELEASE_PULSE_EN
        assign release_nxt[g] = release_c;
`endif
    end

`ifdef KEY_RELEASE_PULSE_EN
    // Output registers including release strobes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_down      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            key_down      <= down_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end
`else
    // Output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_down    <= '0;
            press_pulse <= '0;
        end else begin
            key_down    <= down_nxt;
            press_pulse <= press_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner (NUM_KEYS=2, DEBOUNCE_CYCLES=8).
// The reference model tracks, per key, how many consecutive raw samples disagree with the
// accepted level; a change is accepted after DEBOUNCE_CYCLES+1 such samples and shows up on
// the outputs two edges later (synchronizer stages ahead of the sampling point).
`timescale 1ns/1ps

module tb_key_conditioner;

    localparam int unsigned NK  = 2;
    localparam int unsigned DC  = 8;
    localparam int          LAT = DC + 3;

    typedef struct {
        int         cyc;
        logic [1:0] mask;
    } ev_t;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic [NK-1:0] key_n  = 2'b11;
    logic [NK-1:0] key_down;
    logic [NK-1:0] press_pulse;
`ifdef KEY_RELEASE_PULSE_EN
    logic [NK-1:0] release_pulse;
`endif

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_n       (key_n),
        .key_down    (key_down),
        .press_pulse (press_pulse)
`ifdef KEY_RELEASE_PULSE_EN
        ,
        .release_pulse (release_pulse)
`endif
    );

    always #5 clock = ~clock;

    // Shared state: written by exactly one process each
    int         cyc = 0;
    ev_t        pq[$];
    ev_t        rq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat_id   = 0;
    int         lat_seen = 0;
    int         lat_key  = 0;
    int         lat_ref  = 0;
    logic       done     = 1'b0;

    // Reference model state
    logic [1:0] lvl = '0;
    int         run [2];
    logic [1:0] d1 = '0;
    logic [1:0] d2 = '0;
    logic [1:0] exp_down = '0;
    logic [1:0] pm;
    logic [1:0] rm;
    logic       r;

    // Behavioural model: consecutive-disagreement run length per key
    always @(posedge clock) begin
        cyc = cyc + 1;
        pm  = '0;
        rm  = '0;
        if (!resetn) begin
            lvl      = '0;
            run[0]   = 0;
            run[1]   = 0;
            d1       = '0;
            d2       = '0;
            exp_down = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r = ~key_n[i];
                if (r != lvl[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == int'(DC) + 1) begin
                        lvl[i] = r;
                        run[i] = 0;
                        if (r) pm[i] = 1'b1;
                        else   rm[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            exp_down = d2;
            d2       = d1;
            d1       = lvl;
            if (pm != 0) pq.push_back('{cyc + 2, pm});
            if (rm != 0) rq.push_back('{cyc + 2, rm});
        end
    end

    function automatic void check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    ev_t e;
    logic hit;

    // Monitor: compares DUT outputs with the scoreboard on the falling edge
    always @(negedge clock) begin
        if (!resetn) begin
            check("reset_key_down", int'(key_down), 0);
            check("reset_press_pulse", int'(press_pulse), 0);
`ifdef KEY_RELEASE_PULSE_EN
            check("reset_release_pulse", int'(release_pulse), 0);
`endif
            pq.delete();
            rq.delete();
        end else begin
            check("key_down", int'(key_down), int'(exp_down));

            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                e = pq.pop_front();
                check("press_missed", 0, int'(e.mask));
            end
            hit = (pq.size() > 0) && (pq[0].cyc == cyc);
            if (press_pulse != 0 || hit) begin
                if (hit) begin
                    e = pq.pop_front();
                    check("press_pulse", int'(press_pulse), int'(e.mask));
                end else begin
                    check("press_unexpected", int'(press_pulse), 0);
                end
            end

`ifdef KEY_RELEASE_PULSE_EN
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                e = rq.pop_front();
                check("release_missed", 0, int'(e.mask));
            end
            hit = (rq.size() > 0) && (rq[0].cyc == cyc);
            if (release_pulse != 0 || hit) begin
                if (hit) begin
                    e = rq.pop_front();
                    check("release_pulse", int'(release_pulse), int'(e.mask));
                end else begin
                    check("release_unexpected", int'(release_pulse), 0);
                end
            end
`else
            rq.delete();
`endif

            if (lat_seen != lat_id) begin
                if (press_pulse[lat_key]) begin
                    lat_seen = lat_id;
                    check("press_latency", cyc - lat_ref, LAT);
                end else if (cyc - lat_ref > LAT + 5) begin
                    lat_seen = lat_id;
                    check("press_latency_timeout", cyc - lat_ref, LAT);
                end
            end
        end

        if (done) begin
            check("press_queue_empty", pq.size(), 0);
`ifdef KEY_RELEASE_PULSE_EN
            check("release_queue_empty", rq.size(), 0);
`endif
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end

        if (cyc > 60000) begin
            n_fail = n_fail + 1;
            $display("FAIL watchdog: got cycle %0d expected below 60000", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic arm(input int k);
        lat_key = k;
        lat_ref = cyc;
        lat_id  = lat_id + 1;
    endtask

    // Stimulus
    initial begin
        resetn = 1'b0;
        key_n  = 2'b11;
        tick(4);
        resetn = 1'b1;
        tick(5);

        // Clean press on key 0, held 40 cycles
        key_n[0] = 1'b0;
        arm(0);
        tick(40);
        key_n[0] = 1'b1;
        tick(20);

        // Key 1 bouncing every 3 cycles, then settles pressed
        for (int i = 0; i < 10; i++) begin
            key_n[1] = ~key_n[1];
            tick(3);
        end
        key_n[1] = 1'b0;
        arm(1);
        tick(30);
        key_n[1] = 1'b1;
        tick(20);

        // Both keys on the same edge, released 20 cycles later
        key_n = 2'b00;
        tick(20);
        key_n = 2'b11;
        tick(25);

        // Glitch one sample short of qualification restarts the count
        key_n[0] = 1'b0;
        tick(8);
        key_n[0] = 1'b1;
        tick(1);
        key_n[0] = 1'b0;
        arm(0);
        tick(30);
        key_n[0] = 1'b1;
        tick(20);

        // Key held through a reset
        key_n[0] = 1'b0;
        tick(3);
        resetn = 1'b0;
        tick(5);
        resetn = 1'b1;
        arm(0);
        tick(30);
        key_n[0] = 1'b1;
        tick(20);

        // Reset in the middle of qualification, key released before deassertion
        key_n[0] = 1'b0;
        tick(8);
        resetn = 1'b0;
        tick(2);
        key_n[0] = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(20);

        // Long hold: a single press strobe, no repeat
        key_n[0] = 1'b0;
        tick(1000);
        key_n[0] = 1'b1;
        tick(20);

        // Random levels with random hold lengths and occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                resetn = 1'b0;
                tick(int'($urandom_range(1, 4)));
                resetn = 1'b1;
            end
            key_n = 2'($urandom);
            tick(int'($urandom_range(1, 14)));
        end

        key_n = 2'b11;
        tick(25);
        done = 1'b1;
        tick(5);
    end

endmodule
